sb_dsp: RTL and testbench
=========================

SB_DSP -- requirements
Module: sb_dsp

Interface
REQ-001 Parameter: CLKS_PER_US, default 50, number of clk cycles per microsecond; sample timer base.
REQ-002 Port: clk  in  1  system clock; all logic on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: A  in  10  ISA address.
REQ-005 Port: d_in  in  8  ISA data bus, sampled value.
REQ-006 Port: d_out  out  8  read data to ISA bus.
REQ-007 Port: d_oe  out  1  high = drive d_out onto ISA data bus.
REQ-008 Port: IOR, IOW, AEN, DACK1  in  1 each  raw ISA strobes, all active-low except AEN.
REQ-009 Port: drq  out  1  DMA request, channel 1, active-high.
REQ-010 Port: irq  out  1  interrupt, level, active-high.
REQ-011 Port: pcm  out  8  unsigned 8-bit sample to the audio mixer; 80h = silence.
REQ-012 Port: pcm_valid  out  1  one-cycle pulse when pcm updates.

Function
REQ-013 IOR/IOW each pass through a 2-flop synchroniser; "rise" = history 01, "fall" = history 10.
REQ-014 Port write: on IOW rise with AEN=0 and DACK1=1, decode A and take d_in; writes with DACK1=0 are DMA writes only, with no port decode.
REQ-015 226h write: 1 enters DSP reset: DMA aborted, drq=0, irq=0, output queue flushed, parser idle; a following 0 loads AAh into the output queue.
REQ-016 Output queue: 2 entries, FIFO; push when full drops the new byte.
REQ-017 Reads (AEN=0): d_oe=1 from the cycle after IOR fall through the cycle after IOR rise; d_out latched at the fall.
REQ-018 Reads: 22Ah = queue head (FFh if empty), popped at IOR rise; 22Ch = 00h (always write-ready); 22Eh = {queue_nonempty, 7'h7F}, and irq cleared at IOR rise; other addresses leave d_oe=0.
REQ-019 22Ch writes: command parser, states IDLE, ARG_TC, ARG_LEN_LO, ARG_LEN_HI.
REQ-020 Commands: 40h -> ARG_TC, next byte = time constant TC; 14h -> ARG_LEN_LO, ARG_LEN_HI, then DMA starts; D0h pause; D4h resume; D1h speaker on; D3h speaker off; E1h pushes 02h then 01h; all other codes ignored, stay IDLE.
REQ-021 DMA length: remaining = {hi,lo}+1, 17 bits (FFFFh -> 65536); 14h while active restarts with the new length and clears the byte buffer.
REQ-022 drq=1 when active, not paused, byte buffer empty and remaining>0; drq falls on the cycle after a DMA write.
REQ-023 DMA write: on IOW rise with DACK1=0: buffer<=d_in, buffer full, remaining-=1; at remaining 1->0, irq=1 and active=0 in the same cycle.
REQ-024 Sample timer: period = CLKS_PER_US*(256-TC) cycles; free-running while active and not paused; reloads on expiry and on 40h.
REQ-025 On expiry: if buffer full, pcm<=buffer (80h if speaker off), buffer empties, pcm_valid=1; if empty (underrun), pcm held, no pulse.
REQ-026 Pause holds drq=0 and the timer; buffer and remaining preserved; D4h resumes where paused.
REQ-027 Simultaneous timer expiry and DMA write in one cycle: the old byte goes to pcm, the new byte stays buffered, no loss.
REQ-028 irq stays set until a 22Eh read, a DSP reset or rst; a new set in the clearing cycle wins.

Reset
REQ-029 rst: d_oe=0, d_out=00h, drq=0, irq=0, pcm=80h, pcm_valid=0, queue empty, parser IDLE, DMA inactive, unpaused, speaker off, TC=0, remaining=0, synchronisers=11.
REQ-030 rst overrides every concurrent event, including mid-DMA and mid-read (d_oe drops the next cycle).

Verification
REQ-031 Write 1 then 0 to 226h; read 22Eh -> 80h+7Fh=FFh; read 22Ah -> AAh; read 22Eh -> 7Fh.
REQ-032 Write E1h to 22Ch; read 22Ah twice -> 02h, 01h; third read -> FFh.
REQ-033 Commands D1h, 40h, 9Ch, 14h, 03h, 00h with CLKS_PER_US=2: four DMA bytes 10h/20h/30h/40h -> four pcm_valid pulses 200 cycles apart with those values, then irq=1, drq=0; 22Eh read clears irq.
REQ-034 Start 14h length 0 at 0100h, send D0h after 2 bytes -> drq stays 0, no pcm_valid; D4h -> remaining bytes play, irq after 0101h total.
REQ-035 Withhold DACK1 during DMA -> underrun: pcm holds its last value, no pulses; rst mid-DMA -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/sb_dsp.sv
// Sound Blaster style DSP: ISA port decode, command parser, 8-bit single-cycle DMA
// playback with a microsecond sample timer, a 2-byte read queue and a level IRQ.
module sb_dsp #(
   parameter int CLKS_PER_US = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] A,
   input  logic [7:0] d_in,
   output logic [7:0] d_out,
   output logic       d_oe,
   input  logic       IOR,
   input  logic       IOW,
   input  logic       AEN,
   input  logic       DACK1,
   output logic       drq,
   output logic       irq,
   output logic [7:0] pcm,
   output logic       pcm_valid,
   output logic [1:0] o_dbg_state
);

   localparam logic [9:0] ADDR_RESET  = 10'h226;
   localparam logic [9:0] ADDR_READ   = 10'h22A;
   localparam logic [9:0] ADDR_WRITE  = 10'h22C;
   localparam logic [9:0] ADDR_STATUS = 10'h22E;
   localparam int         TW          = $clog2(CLKS_PER_US * 256);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_ARG_TC     = 2'd1,
      S_ARG_LEN_LO = 2'd2,
      S_ARG_LEN_HI = 2'd3
   } parse_t;

   // Reload value of the sample timer: one sample period minus one cycle.
   function automatic logic [TW-1:0] period_m1(input logic [7:0] tc);
      logic [31:0] p;
      p = CLKS_PER_US * (32'd256 - {24'd0, tc});
      return TW'(p - 32'd1);
   endfunction

   // ---------------- strobe synchronisers ----------------
   logic [1:0] r_ior_s, r_iow_s;
   logic       w_ior_fall, w_ior_rise, w_iow_rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ior_s <= 2'b11;
         r_iow_s <= 2'b11;
      end else begin
         r_ior_s <= {r_ior_s[0], IOR};
         r_iow_s <= {r_iow_s[0], IOW};
      end
   end

   assign w_ior_fall = (r_ior_s == 2'b10);
   assign w_ior_rise = (r_ior_s == 2'b01);
   assign w_iow_rise = (r_iow_s == 2'b01);

   // ---------------- register state ----------------
   parse_t      r_state, w_state_next;
   logic [1:0][7:0] r_q;
   logic [1:0]  r_q_cnt;
   logic        r_in_reset;
   logic        r_rd_pend, r_d_oe;
   logic [9:0]  r_rd_addr;
   logic [7:0]  r_d_out;
   logic        r_active, r_paused, r_speaker;
   logic [7:0]  r_tc, r_len_lo, r_buf, r_pcm;
   logic        r_buf_full, r_pcm_valid, r_irq;
   logic [16:0] r_remaining;
   logic [TW-1:0] r_timer;

   // ---------------- write decode ----------------
   logic w_port_wr, w_dma_wr, w_dsp_rst_wr, w_dsp_rst_rel, w_cmd_wr;

   assign w_port_wr     = w_iow_rise & ~AEN & DACK1;
   assign w_dma_wr      = w_iow_rise & ~DACK1 & r_active;
   assign w_dsp_rst_wr  = w_port_wr & (A == ADDR_RESET) & d_in[0];
   assign w_dsp_rst_rel = w_port_wr & (A == ADDR_RESET) & ~d_in[0] & r_in_reset;
   assign w_cmd_wr      = w_port_wr & (A == ADDR_WRITE);

   // ---------------- read path ----------------
   logic       w_rd_hit, w_rd_end, w_pop, w_irq_clr, w_q_nonempty;
   logic [7:0] w_rd_data;

   assign w_q_nonempty = (r_q_cnt != 2'd0);
   assign w_rd_hit = w_ior_fall & ~AEN &
                     ((A == ADDR_READ) | (A == ADDR_WRITE) | (A == ADDR_STATUS));
   assign w_rd_end  = w_ior_rise & r_rd_pend;
   assign w_pop     = w_rd_end & (r_rd_addr == ADDR_READ);
   assign w_irq_clr = w_rd_end & (r_rd_addr == ADDR_STATUS);

   always_comb begin
      w_rd_data = 8'h00;
      if (A == ADDR_READ)
         w_rd_data = w_q_nonempty ? r_q[0] : 8'hFF;
      else if (A == ADDR_STATUS)
         w_rd_data = {w_q_nonempty, 7'h7F};
   end

   // d_oe stays up for one extra cycle after the IOR rise to cover bus hold time.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_pend <= 1'b0;
         r_d_oe    <= 1'b0;
         r_rd_addr <= 10'd0;
         r_d_out   <= 8'h00;
      end else begin
         r_d_oe <= r_rd_pend | w_rd_hit;
         if (w_rd_hit) begin
            r_rd_pend <= 1'b1;
            r_rd_addr <= A;
            r_d_out   <= w_rd_data;
         end else if (w_ior_rise) begin
            r_rd_pend <= 1'b0;
         end
      end
   end

   // ---------------- command parser FSM ----------------
   logic w_tc_load, w_len_lo_load, w_dma_start, w_pause, w_resume;
   logic w_spk_on, w_spk_off, w_ident;

   always_ff @(posedge clk) begin
      if (rst || w_dsp_rst_wr)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (w_cmd_wr) begin
         case (r_state)
            S_IDLE: begin
               if (d_in == 8'h40)
                  w_state_next = S_ARG_TC;
               else if (d_in == 8'h14)
                  w_state_next = S_ARG_LEN_LO;
            end
            S_ARG_TC:     w_state_next = S_IDLE;
            S_ARG_LEN_LO: w_state_next = S_ARG_LEN_HI;
            S_ARG_LEN_HI: w_state_next = S_IDLE;
            default:      w_state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_tc_load     = 1'b0;
      w_len_lo_load = 1'b0;
      w_dma_start   = 1'b0;
      w_pause       = 1'b0;
      w_resume      = 1'b0;
      w_spk_on      = 1'b0;
      w_spk_off     = 1'b0;
      w_ident       = 1'b0;
      if (w_cmd_wr) begin
         case (r_state)
            S_IDLE: begin
               case (d_in)
                  8'hD0:   w_pause  = 1'b1;
                  8'hD4:   w_resume = 1'b1;
                  8'hD1:   w_spk_on = 1'b1;
                  8'hD3:   w_spk_off = 1'b1;
                  8'hE1:   w_ident  = 1'b1;
                  default: ;
               endcase
            end
            S_ARG_TC:     w_tc_load     = 1'b1;
            S_ARG_LEN_LO: w_len_lo_load = 1'b1;
            S_ARG_LEN_HI: w_dma_start   = 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- output queue ----------------
   logic [1:0]      w_push_en;
   logic [1:0][7:0] w_push_data;
   logic [1:0][7:0] w_q_next;
   logic [1:0]      w_q_cnt_next;

   assign w_push_en[0]   = w_dsp_rst_rel | w_ident;
   assign w_push_data[0] = w_ident ? 8'h02 : 8'hAA;
   assign w_push_en[1]   = w_ident;
   assign w_push_data[1] = 8'h01;

   // Pop is applied before pushes so a read and a push in one cycle both land.
   always_comb begin
      w_q_next     = r_q;
      w_q_cnt_next = r_q_cnt;
      if (w_dsp_rst_wr) begin
         w_q_cnt_next = 2'd0;
      end else if (w_pop && (r_q_cnt != 2'd0)) begin
         w_q_next[0]  = r_q[1];
         w_q_cnt_next = r_q_cnt - 2'd1;
      end
      for (int i = 0; i < 2; i++) begin
         if (w_push_en[i]) begin
            if (w_q_cnt_next == 2'd0) begin
               w_q_next[0]  = w_push_data[i];
               w_q_cnt_next = 2'd1;
            end else if (w_q_cnt_next == 2'd1) begin
               w_q_next[1]  = w_push_data[i];
               w_q_cnt_next = 2'd2;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q        <= '0;
         r_q_cnt    <= 2'd0;
         r_in_reset <= 1'b0;
      end else begin
         r_q     <= w_q_next;
         r_q_cnt <= w_q_cnt_next;
         if (w_dsp_rst_wr)
            r_in_reset <= 1'b1;
         else if (w_dsp_rst_rel)
            r_in_reset <= 1'b0;
      end
   end

   // ---------------- DMA playback ----------------
   logic w_timer_run, w_expire, w_irq_set;

   // The timer keeps running after the last DMA byte until that byte has played.
   assign w_timer_run = (r_active | r_buf_full) & ~r_paused;
   assign w_expire    = w_timer_run & (r_timer == '0);
   assign w_irq_set   = w_dma_wr & (r_remaining == 17'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_active    <= 1'b0;
         r_paused    <= 1'b0;
         r_speaker   <= 1'b0;
         r_tc        <= 8'h00;
         r_len_lo    <= 8'h00;
         r_remaining <= 17'd0;
         r_buf       <= 8'h00;
         r_buf_full  <= 1'b0;
         r_pcm       <= 8'h80;
         r_pcm_valid <= 1'b0;
         r_irq       <= 1'b0;
         r_timer     <= period_m1(8'h00);
      end else begin
         r_pcm_valid <= 1'b0;
         if (w_tc_load)     r_tc     <= d_in;
         if (w_len_lo_load) r_len_lo <= d_in;
         if (w_spk_on)      r_speaker <= 1'b1;
         if (w_spk_off)     r_speaker <= 1'b0;
         if (w_pause)       r_paused <= 1'b1;
         if (w_resume)      r_paused <= 1'b0;

         if (w_tc_load)
            r_timer <= period_m1(d_in);
         else if (w_timer_run)
            r_timer <= (r_timer == '0) ? period_m1(r_tc) : r_timer - 1'b1;

         if (w_expire && r_buf_full) begin
            r_pcm       <= r_speaker ? r_buf : 8'h80;
            r_pcm_valid <= 1'b1;
         end

         // A DMA byte arriving on an expiry refills the buffer the expiry just drained.
         if (w_dsp_rst_wr || w_dma_start) begin
            r_buf_full <= 1'b0;
         end else if (w_dma_wr) begin
            r_buf      <= d_in;
            r_buf_full <= 1'b1;
         end else if (w_expire) begin
            r_buf_full <= 1'b0;
         end

         if (w_dsp_rst_wr) begin
            r_active    <= 1'b0;
            r_remaining <= 17'd0;
         end else if (w_dma_start) begin
            r_active    <= 1'b1;
            r_remaining <= {1'b0, d_in, r_len_lo} + 17'd1;
         end else if (w_dma_wr) begin
            r_remaining <= r_remaining - 17'd1;
            if (r_remaining == 17'd1)
               r_active <= 1'b0;
         end

         if (w_dsp_rst_wr)
            r_irq <= 1'b0;
         else if (w_irq_set)
            r_irq <= 1'b1;
         else if (w_irq_clr)
            r_irq <= 1'b0;
      end
   end

   assign drq         = r_active & ~r_paused & ~r_buf_full & (r_remaining != 17'd0);
   assign irq         = r_irq;
   assign pcm         = r_pcm;
   assign pcm_valid   = r_pcm_valid;
   assign d_out       = r_d_out;
   assign d_oe        = r_d_oe;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sb_dsp.sv
// Directed bench for sb_dsp: port reset/ident, a timed DMA playback, pause/resume,
// underrun, speaker mute and a reset landing in the middle of a DMA and a read.
module tb_sb_dsp;
  localparam int CLKS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] A;
  logic [7:0] d_in, d_out, pcm;
  logic       d_oe, IOR, IOW, AEN, DACK1, drq, irq, pcm_valid;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int n_pulses = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         t_q[$];

  sb_dsp #(.CLKS_PER_US(CLKS)) dut (
    .clk(clk), .rst(rst), .A(A), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
    .IOR(IOR), .IOW(IOW), .AEN(AEN), .DACK1(DACK1), .drq(drq), .irq(irq),
    .pcm(pcm), .pcm_valid(pcm_valid), .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // pcm monitor: every pulse is logged with its cycle number
  always @(negedge clk) begin
    cycle++;
    if (pcm_valid === 1'b1) begin
      got_q.push_back(pcm);
      t_q.push_back(cycle);
      n_pulses++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver tasks
  task automatic io_write(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    AEN = 1'b0; DACK1 = 1'b1; A = a; d_in = d; IOW = 1'b0;
    tick(4);
    IOW = 1'b1;
    tick(4);
  endtask

  task automatic read_check(input string tag, input logic [9:0] a, input logic [7:0] expv);
    logic [7:0] d;
    logic       oe_mid;
    @(negedge clk);
    AEN = 1'b0; A = a; IOR = 1'b0;
    tick(4);
    d = d_out; oe_mid = d_oe;
    IOR = 1'b1;
    tick(4);
    check({tag, " data"}, d, expv);
    check({tag, " oe"}, oe_mid, 1);
    check({tag, " oe off"}, d_oe, 0);
  endtask

  task automatic dma_write(input logic [7:0] d);
    @(negedge clk);
    AEN = 1'b1; DACK1 = 1'b0; d_in = d; IOW = 1'b0;
    tick(4);
    IOW = 1'b1;
    tick(4);
    DACK1 = 1'b1; AEN = 1'b0;
  endtask

  task automatic serve(input logic [7:0] d, input logic [7:0] expv);
    int k;
    k = 0;
    while (drq !== 1'b1 && k < 2000) begin
      tick(1);
      k++;
    end
    if (drq !== 1'b1) check("drq wait", drq, 1);
    dma_write(d);
    exp_q.push_back(expv);
  endtask

  task automatic wait_pulses(input int target);
    int k;
    k = 0;
    while (n_pulses < target && k < 20000) begin
      tick(1);
      k++;
    end
    check("pulse total", n_pulses, target);
  endtask

  // scoreboard drain
  task automatic compare_pulses(input string tag);
    check({tag, " count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, " pcm"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
    t_q.delete();
  endtask

  initial begin
    int   base, n0;
    logic seen;

    rst = 1'b1; A = '0; d_in = '0; IOR = 1'b1; IOW = 1'b1; AEN = 1'b0; DACK1 = 1'b1;
    tick(3);
    check("rst d_oe", d_oe, 0);
    check("rst d_out", d_out, 8'h00);
    check("rst drq", drq, 0);
    check("rst irq", irq, 0);
    check("rst pcm", pcm, 8'h80);
    check("rst pcm_valid", pcm_valid, 0);
    rst = 1'b0;
    tick(2);
    check("rst state", dbg_state, 0);

    // DSP reset handshake and status/read port
    io_write(10'h226, 8'h01);
    io_write(10'h226, 8'h00);
    read_check("status full", 10'h22E, 8'hFF);
    read_check("reset ack", 10'h22A, 8'hAA);
    read_check("status empty", 10'h22E, 8'h7F);
    read_check("write ready", 10'h22C, 8'h00);

    // ident command fills both queue entries
    io_write(10'h22C, 8'hE1);
    read_check("ident 0", 10'h22A, 8'h02);
    read_check("ident 1", 10'h22A, 8'h01);
    read_check("queue empty", 10'h22A, 8'hFF);

    // timed playback: TC=9Ch -> 100 us -> 200 cycles per sample
    io_write(10'h22C, 8'hD1);
    io_write(10'h22C, 8'h40);
    io_write(10'h22C, 8'h9C);
    check("state arg_tc done", dbg_state, 0);
    io_write(10'h22C, 8'h14);
    check("state len_lo", dbg_state, 2);
    io_write(10'h22C, 8'h03);
    check("state len_hi", dbg_state, 3);
    io_write(10'h22C, 8'h00);
    base = n_pulses;
    for (int i = 1; i <= 4; i++) serve(8'(i * 16), 8'(i * 16));
    wait_pulses(base + 4);
    for (int i = 1; i < 4 && i < t_q.size(); i++)
      check("sample spacing", t_q[i] - t_q[i-1], 200);
    compare_pulses("play4");
    check("play4 irq", irq, 1);
    check("play4 drq", drq, 0);
    read_check("irq ack", 10'h22E, 8'h7F);
    check("irq cleared", irq, 0);

    // pause after two bytes of a 0101h-byte transfer, then resume
    io_write(10'h22C, 8'h40);
    io_write(10'h22C, 8'hF6);
    io_write(10'h22C, 8'h14);
    io_write(10'h22C, 8'h00);
    io_write(10'h22C, 8'h01);
    base = n_pulses;
    for (int i = 0; i < 2; i++) serve(8'(i * 3 + 1), 8'(i * 3 + 1));
    io_write(10'h22C, 8'hD0);
    n0 = n_pulses;
    seen = 1'b0;
    repeat (100) begin
      tick(1);
      if (drq !== 1'b0) seen = 1'b1;
    end
    check("paused drq", seen, 0);
    check("paused pulses", n_pulses, n0);
    io_write(10'h22C, 8'hD4);
    for (int i = 2; i < 257; i++) serve(8'(i * 3 + 1), 8'(i * 3 + 1));
    check("long irq", irq, 1);
    wait_pulses(base + 257);
    compare_pulses("long");
    check("long drq", drq, 0);
    read_check("long irq ack", 10'h22E, 8'h7F);
    check("long irq cleared", irq, 0);

    // underrun, speaker mute, then reset mid-DMA and mid-read
    io_write(10'h22C, 8'h14);
    io_write(10'h22C, 8'h03);
    io_write(10'h22C, 8'h00);
    base = n_pulses;
    serve(8'h77, 8'h77);
    wait_pulses(base + 1);
    compare_pulses("first");
    n0 = n_pulses;
    seen = 1'b0;
    repeat (100) begin
      tick(1);
      if (drq !== 1'b1) seen = 1'b1;
    end
    check("underrun pulses", n_pulses, n0);
    check("underrun pcm hold", pcm, 8'h77);
    check("underrun drq held", seen, 0);
    io_write(10'h22C, 8'hD3);
    serve(8'h99, 8'h80);
    wait_pulses(n0 + 1);
    compare_pulses("muted");
    io_write(10'h22C, 8'hD1);
    serve(8'h55, 8'h55);
    wait_pulses(n0 + 2);
    compare_pulses("unmuted");
    check("pre-rst drq", drq, 1);

    @(negedge clk);
    AEN = 1'b0; A = 10'h22A; IOR = 1'b0;
    tick(4);
    check("mid-read oe", d_oe, 1);
    check("mid-read data", d_out, 8'hFF);
    rst = 1'b1;
    tick(1);
    check("rst2 d_oe", d_oe, 0);
    check("rst2 d_out", d_out, 8'h00);
    check("rst2 drq", drq, 0);
    check("rst2 irq", irq, 0);
    check("rst2 pcm", pcm, 8'h80);
    check("rst2 pcm_valid", pcm_valid, 0);
    check("rst2 state", dbg_state, 0);
    IOR = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    check("post-rst drq", drq, 0);
    check("post-rst oe", d_oe, 0);
    read_check("post-rst queue", 10'h22A, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
